// File: rtl/instr_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath / instruction memory.
// Fetch handshake: imem_req is held for every FETCH cycle; a transfer happens in the cycle where imem_req and imem_ack are both 1.
interface instr_sequencer_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) ();
    logic [PC_WIDTH-1:0]  startPC;
    logic                 run;
    logic [4:0]           opcode;
    logic                 imem_ack;
    logic [PC_WIDTH-1:0]  pc;
    logic                 imem_req;
    logic                 ir_load;
    logic [3:0]           alu_op;
    logic                 regWrite;
    logic                 C_ART_reg;
    logic                 C_ART_data;
    logic [2:0]           state;
    logic                 halted;
    logic                 fault;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  startPC, run, opcode, imem_ack,
        output pc, imem_req, ir_load, alu_op, regWrite, C_ART_reg, C_ART_data,
               state, halted, fault, retired
    );

    modport slave (
        output startPC, run, opcode, imem_ack,
        input  pc, imem_req, ir_load, alu_op, regWrite, C_ART_reg, C_ART_data,
               state, halted, fault, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: owns the PC, commits one instruction per
// 4+ cycle pass, and stops in HALT or FAULT until reset.
module instr_sequencer #(
    parameter int PC_WIDTH   = 32,
    parameter int PC_STEP    = 4,
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    instr_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

    localparam logic [4:0] OP_AR   = 5'b00000;
    localparam logic [4:0] OP_T    = 5'b00001;
    localparam logic [4:0] OP_HALT = 5'b11111;
    localparam logic [3:0] ALU_AR  = 4'b0010;
    localparam logic [3:0] ALU_T   = 4'b0000;

    state_t               state_r;
    logic [PC_WIDTH-1:0]  pc_r;
    logic [CNT_WIDTH-1:0] retired_r;
    logic [WCW-1:0]       wait_cnt;
    logic                 cls_t;
    logic                 req_r;
    logic [3:0]           alu_op_r;
    logic                 rw_r;
    logic                 art_r;
    logic                 halted_r;
    logic                 fault_r;

    // Outputs are registered for the state being entered, so each branch sets them
    // explicitly on its transition; one-cycle signals fall back to 0 otherwise.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= S_IDLE;
            pc_r      <= bus.startPC;
            retired_r <= '0;
            wait_cnt  <= '0;
            cls_t     <= 1'b0;
            req_r     <= 1'b0;
            alu_op_r  <= 4'b0000;
            rw_r      <= 1'b0;
            art_r     <= 1'b0;
            halted_r  <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            req_r    <= 1'b0;
            alu_op_r <= 4'b0000;
            rw_r     <= 1'b0;
            art_r    <= 1'b0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    pc_r     <= bus.startPC;
                    wait_cnt <= '0;
                    if (bus.run) begin
                        state_r <= S_FETCH;
                        req_r   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        state_r  <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_r  <= S_FAULT;
                        fault_r  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                        req_r    <= 1'b1;
                    end
                end
                S_DECODE: begin
                    // The class is latched here; opcode is not looked at again.
                    case (bus.opcode)
                        OP_AR: begin
                            state_r  <= S_EXEC;
                            cls_t    <= 1'b0;
                            alu_op_r <= ALU_AR;
                            art_r    <= 1'b0;
                        end
                        OP_T: begin
                            state_r  <= S_EXEC;
                            cls_t    <= 1'b1;
                            alu_op_r <= ALU_T;
                            art_r    <= 1'b1;
                        end
                        OP_HALT: begin
                            state_r  <= S_HALT;
                            halted_r <= 1'b1;
                        end
                        default: begin
                            state_r <= S_FAULT;
                            fault_r <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    state_r  <= S_WB;
                    rw_r     <= 1'b1;
                    alu_op_r <= alu_op_r;
                    art_r    <= cls_t;
                end
                S_WB: begin
                    state_r <= S_FETCH;
                    req_r   <= 1'b1;
                    pc_r    <= pc_r + PC_WIDTH'(PC_STEP);
                    if (retired_r != {CNT_WIDTH{1'b1}})
                        retired_r <= retired_r + CNT_WIDTH'(1);
                end
                S_HALT: begin
                    halted_r <= 1'b1;
                end
                S_FAULT: begin
                    fault_r <= 1'b1;
                end
                default: begin
                    state_r <= S_FAULT;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc         = pc_r;
    assign bus.imem_req   = req_r;
    assign bus.ir_load    = req_r & bus.imem_ack;
    assign bus.alu_op     = alu_op_r;
    assign bus.regWrite   = rw_r;
    assign bus.C_ART_reg  = art_r;
    assign bus.C_ART_data = art_r;
    assign bus.state      = state_r;
    assign bus.halted     = halted_r;
    assign bus.fault      = fault_r;
    assign bus.retired    = retired_r;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset/idle, AR and T instructions, fetch wait and
// timeout, HALT and illegal opcodes, mid-instruction reset and PC wrap.
module tb_instr_sequencer;
    logic CLK;
    logic RESET;
    int   n_pass  = 0;
    int   n_total = 0;
    int   rw_pulses  = 0;
    int   req_cycles = 0;

    instr_sequencer_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus ();

    instr_sequencer #(
        .PC_WIDTH(32), .PC_STEP(4), .WAIT_LIMIT(15), .CNT_WIDTH(16)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.regWrite) rw_pulses++;
        if (bus.imem_req) req_cycles++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic do_reset(input logic [31:0] spc);
        RESET       = 1'b1;
        bus.startPC = spc;
        bus.run     = 1'b0;
        bus.imem_ack = 1'b0;
        bus.opcode  = 5'b00000;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Caller leaves the DUT in the first FETCH cycle; returns in the next FETCH cycle.
    task automatic do_instr(input string tag, input logic [4:0] op, input int ack_delay,
                            input logic [31:0] pc0, input logic is_t);
        int          rw0;
        logic [31:0] pc_next;
        rw0     = rw_pulses;
        pc_next = pc0 + 32'd4;
        bus.opcode = op;
        for (int i = 0; i < ack_delay; i++) begin
            bus.imem_ack = 1'b0;
            #1;
            check({tag, " wait state"}, 32'(bus.state), 32'd1);
            check({tag, " wait req"}, 32'(bus.imem_req), 32'd1);
            check({tag, " wait ir_load"}, 32'(bus.ir_load), 32'd0);
            tick();
        end
        bus.imem_ack = 1'b1;
        #1;
        check({tag, " fetch state"}, 32'(bus.state), 32'd1);
        check({tag, " ir_load"}, 32'(bus.ir_load), 32'd1);
        tick();
        bus.imem_ack = 1'b0;
        check({tag, " decode state"}, 32'(bus.state), 32'd2);
        check({tag, " decode req"}, 32'(bus.imem_req), 32'd0);
        tick();
        bus.opcode = 5'b10101;
        check({tag, " exec state"}, 32'(bus.state), 32'd3);
        check({tag, " exec alu_op"}, 32'(bus.alu_op), is_t ? 32'd0 : 32'd2);
        check({tag, " exec C_ART_reg"}, 32'(bus.C_ART_reg), 32'(is_t));
        check({tag, " exec C_ART_data"}, 32'(bus.C_ART_data), 32'(is_t));
        check({tag, " exec regWrite"}, 32'(bus.regWrite), 32'd0);
        tick();
        check({tag, " wb state"}, 32'(bus.state), 32'd4);
        check({tag, " wb regWrite"}, 32'(bus.regWrite), 32'd1);
        check({tag, " wb alu_op"}, 32'(bus.alu_op), is_t ? 32'd0 : 32'd2);
        check({tag, " wb C_ART_reg"}, 32'(bus.C_ART_reg), 32'(is_t));
        check({tag, " wb pc"}, bus.pc, pc0);
        tick();
        check({tag, " next state"}, 32'(bus.state), 32'd1);
        check({tag, " next pc"}, bus.pc, pc_next);
        check({tag, " regWrite pulses"}, 32'(rw_pulses - rw0), 32'd1);
    endtask

    initial begin
        int rw0;
        int req0;

        // 1: reset and idle
        do_reset(32'h100);
        tick(); tick();
        bus.imem_ack = 1'b1;
        tick();
        check("idle pc", bus.pc, 32'h100);
        check("idle state", 32'(bus.state), 32'd0);
        check("idle req", 32'(bus.imem_req), 32'd0);
        check("idle ir_load", 32'(bus.ir_load), 32'd0);
        check("idle regWrite", 32'(bus.regWrite), 32'd0);
        check("idle alu_op", 32'(bus.alu_op), 32'd0);
        check("idle flags", {30'd0, bus.halted, bus.fault}, 32'd0);
        check("idle retired", 32'(bus.retired), 32'd0);

        // 2: three AR instructions, zero-wait fetch
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        do_instr("ar0", 5'b00000, 0, 32'h100, 1'b0);
        do_instr("ar1", 5'b00000, 0, 32'h104, 1'b0);
        do_instr("ar2", 5'b00000, 0, 32'h108, 1'b0);
        check("ar retired", 32'(bus.retired), 32'd3);
        check("ar pc", bus.pc, 32'h10C);

        // 3: T instruction with two wait cycles
        do_instr("t0", 5'b00001, 2, 32'h10C, 1'b1);
        check("t retired", 32'(bus.retired), 32'd4);

        // 4: fetch timeout
        bus.imem_ack = 1'b0;
        rw0  = rw_pulses;
        req0 = req_cycles;
        for (int i = 0; i < 14; i++) tick();
        check("timeout still fetching", 32'(bus.state), 32'd1);
        tick();
        check("timeout state", 32'(bus.state), 32'd6);
        check("timeout fault", 32'(bus.fault), 32'd1);
        tick(); tick(); tick();
        check("timeout req cycles", 32'(req_cycles - req0), 32'd15);
        check("timeout fault held", 32'(bus.fault), 32'd1);
        check("timeout pc", bus.pc, 32'h110);
        check("timeout regWrite", 32'(rw_pulses - rw0), 32'd0);
        check("timeout retired", 32'(bus.retired), 32'd4);

        // 5a: AR then HALT; run ignored afterwards
        do_reset(32'h200);
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        do_instr("pre_halt", 5'b00000, 0, 32'h200, 1'b0);
        bus.opcode   = 5'b11111;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("halt state", 32'(bus.state), 32'd5);
        check("halt halted", 32'(bus.halted), 32'd1);
        check("halt retired", 32'(bus.retired), 32'd1);
        bus.run = 1'b1; tick();
        bus.run = 1'b0; tick();
        bus.run = 1'b1; tick();
        bus.run = 1'b0; tick();
        check("halt held", 32'(bus.halted), 32'd1);
        check("halt pc frozen", bus.pc, 32'h204);
        check("halt no req", 32'(bus.imem_req), 32'd0);
        check("halt fault", 32'(bus.fault), 32'd0);

        // 5b: illegal opcode from fresh reset
        do_reset(32'h300);
        check("rst halted clear", 32'(bus.halted), 32'd0);
        bus.run = 1'b1;
        tick();
        bus.run      = 1'b0;
        bus.opcode   = 5'b00101;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("illegal state", 32'(bus.state), 32'd6);
        check("illegal fault", 32'(bus.fault), 32'd1);
        check("illegal retired", 32'(bus.retired), 32'd0);
        check("illegal pc", bus.pc, 32'h300);

        // 6a: reset during EXEC aborts the write
        do_reset(32'h400);
        bus.run = 1'b1;
        tick();
        bus.run      = 1'b0;
        bus.opcode   = 5'b00000;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("abort in exec", 32'(bus.state), 32'd3);
        rw0   = rw_pulses;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("abort state", 32'(bus.state), 32'd0);
        check("abort regWrite", 32'(bus.regWrite), 32'd0);
        check("abort pc", bus.pc, 32'h400);
        check("abort retired", 32'(bus.retired), 32'd0);
        tick();
        check("abort no pulse", 32'(rw_pulses - rw0), 32'd0);

        // 6b: PC wrap, startPC picked up while idle
        bus.startPC = 32'hFFFF_FFFC;
        tick();
        check("wrap idle pc", bus.pc, 32'hFFFF_FFFC);
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        do_instr("wrap", 5'b00000, 0, 32'hFFFF_FFFC, 1'b0);
        check("wrap pc zero", bus.pc, 32'h0000_0000);
        check("wrap retired", 32'(bus.retired), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
